// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one-deep memory pipeline and 2-entry buffer
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   fetch_enable    permits new fetch issues
//   mem_en          read request to instruction memory this cycle
//   mem_addr_32     byte address of the read (PC - PC_BASE_ADDR)
//   mem_data_32     read data, valid one cycle after mem_en
//   instr_valid     buffer head holds a valid instruction
//   instr_ready     decoder accepts the head
//   instr_32        instruction word at the buffer head
//   instr_pc_32     PC of instr_32
//   redirect_valid  branch/jump redirect request
//   redirect_pc_32  redirect target (low two bits ignored)
//   fetch_count_32  count of completed transfers (wraps)

module fetch_unit #(
  parameter logic [31:0] PC_BASE_ADDR = 32'h80020000,
  parameter int          DEPTH        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic        mem_en,
  output logic [31:0] mem_addr_32,
  input  logic [31:0] mem_data_32,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_32,
  output logic [31:0] instr_pc_32,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc_32,
  output logic [31:0] fetch_count_32
);

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_pc_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;
  logic [31:0] fetch_count_q;
  // Held low through reset and the cycle reset deasserts, so release is
  // seen synchronously and no issue happens in the release cycle.
  logic        run_q;

  logic        pop;
  logic        capture;
  logic        issue;
  logic [2:0]  pending;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc_32 & ~32'h3;

  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid & instr_ready;

  // A redirect discards the response arriving this cycle.
  assign capture     = inflight_q & ~redirect_valid;

  // Slots already committed after this cycle's pop; the in-flight read
  // reserves its slot so the buffer can never overflow.
  assign pending     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = run_q & fetch_enable & ~redirect_valid & (pending < 3'(DEPTH));

  assign mem_en         = issue;
  assign mem_addr_32    = pc_q - PC_BASE_ADDR;
  assign instr_32       = instr_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign instr_pc_32    = instr_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
  assign fetch_count_32 = fetch_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      pc_q          <= PC_BASE_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      fetch_count_q <= 32'h0;
    end else begin
      run_q <= 1'b1;

      if (redirect_valid) begin
        pc_q <= redirect_target;
      end else if (issue) begin
        pc_q <= pc_q + 32'd4;
      end

      // The response of the previous issue is consumed this cycle, so the
      // flag only survives when a new issue replaces it.
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end

      if (redirect_valid) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (capture) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q <= count_q + {1'b0, capture} - {1'b0, pop};
      end

      // A transfer coincident with a redirect still completes.
      if (pop) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      buf_instr_q[wr_ptr_q] <= mem_data_32;
      buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h80020000;

  logic        clock;
  logic        reset;
  logic        fetch_enable;
  logic        mem_en;
  logic [31:0] mem_addr_32;
  logic [31:0] mem_data_32;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_32;
  logic [31:0] instr_pc_32;
  logic        redirect_valid;
  logic [31:0] redirect_pc_32;
  logic [31:0] fetch_count_32;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.PC_BASE_ADDR(BASE), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .mem_en         (mem_en),
    .mem_addr_32    (mem_addr_32),
    .mem_data_32    (mem_data_32),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_32       (instr_32),
    .instr_pc_32    (instr_pc_32),
    .redirect_valid (redirect_valid),
    .redirect_pc_32 (redirect_pc_32),
    .fetch_count_32 (fetch_count_32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_head(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, {31'b0, instr_valid}, {31'b0, v});
    if (v) begin
      check({name, "_pc"}, instr_pc_32, pc);
      check({name, "_instr"}, instr_32, tag(pc - BASE));
    end
  endtask

  task automatic check_issue(input string name, input logic en, input logic [31:0] addr);
    check({name, "_mem_en"}, {31'b0, mem_en}, {31'b0, en});
    if (en) check({name, "_addr"}, mem_addr_32, addr);
  endtask

  // Memory responds one cycle after a request with an address-tagged word.
  task automatic tick();
    logic        en;
    logic [31:0] a;
    en = mem_en;
    a  = mem_addr_32;
    @(posedge clock);
    #1;
    mem_data_32 = en ? tag(a) : 32'hDEADBEEF;
  endtask

  initial begin
    reset          = 1'b0;
    fetch_enable   = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc_32 = 32'h0;
    mem_data_32    = 32'h0;
    tick();
    tick();

    // Reset state, with fetch_enable already high
    fetch_enable = 1'b1;
    #1;
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_addr", mem_addr_32, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr_32, 32'h0);
    check("rst_pc", instr_pc_32, 32'h0);
    check("rst_count", fetch_count_32, 32'h0);

    // Release cycle: no issue
    reset = 1'b1;
    #1;
    check("release_no_issue", {31'b0, mem_en}, 32'h0);
    tick();

    // Streaming: issue every cycle, first instruction two cycles after first issue
    instr_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check_issue("stream", 1'b1, 32'(4 * (k - 1)));
      check_head("stream", k >= 3, BASE + 32'(4 * (k - 3)));
      if (k >= 3) check("stream_count", fetch_count_32, 32'(k - 3));
      tick();
    end

    // Back-pressure for five cycles: buffer fills, issue stops, head stable
    instr_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_issue("stall", 1'b0, 32'h0);
      check_head("stall", 1'b1, BASE + 32'h10);
      tick();
    end

    // Release: in-order drain and resumed issue
    instr_ready = 1'b1;
    #1;
    check_issue("resume0", 1'b1, 32'h18);
    check_head("resume0", 1'b1, BASE + 32'h10);
    check("resume0_count", fetch_count_32, 32'd4);
    tick();
    #1;
    check_issue("resume1", 1'b1, 32'h1C);
    check_head("resume1", 1'b1, BASE + 32'h14);
    check("resume1_count", fetch_count_32, 32'd5);
    tick();
    #1;
    check_issue("resume2", 1'b1, 32'h20);
    check_head("resume2", 1'b1, BASE + 32'h18);
    check("resume2_count", fetch_count_32, 32'd6);
    tick();

    // Redirect with a buffered entry and a read in flight, no transfer
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc_32 = 32'h80020103;
    #1;
    check_issue("redir_cycle", 1'b0, 32'h0);
    check_head("redir_cycle", 1'b1, BASE + 32'h1C);
    check("redir_cycle_count", fetch_count_32, 32'd7);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #1;
    check_head("redir_r1", 1'b0, 32'h0);
    check_issue("redir_r1", 1'b1, 32'h100);
    tick();
    #1;
    check_head("redir_r2", 1'b0, 32'h0);
    check_issue("redir_r2", 1'b1, 32'h104);
    tick();
    #1;
    check_head("redir_r3", 1'b1, 32'h80020100);
    check_issue("redir_r3", 1'b1, 32'h108);
    tick();
    #1;
    check_head("redir_r4", 1'b1, 32'h80020104);
    check("redir_r4_count", fetch_count_32, 32'd8);
    tick();

    // Redirect coincident with a transfer
    redirect_valid = 1'b1;
    redirect_pc_32 = 32'h80020040;
    #1;
    check_head("redxfer", 1'b1, 32'h80020108);
    check("redxfer_count", fetch_count_32, 32'd9);
    check_issue("redxfer", 1'b0, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_head("redxfer_r1", 1'b0, 32'h0);
    check("redxfer_r1_count", fetch_count_32, 32'd10);
    check_issue("redxfer_r1", 1'b1, 32'h40);
    tick();
    #1;
    check_head("redxfer_r2", 1'b0, 32'h0);
    check_issue("redxfer_r2", 1'b1, 32'h44);
    tick();
    #1;
    check_head("redxfer_r3", 1'b1, 32'h80020040);
    check("redxfer_r3_count", fetch_count_32, 32'd10);
    tick();

    // fetch_enable low: no issue, in-flight read and buffer still drain
    fetch_enable = 1'b0;
    #1;
    check_issue("fe_off0", 1'b0, 32'h0);
    check_head("fe_off0", 1'b1, 32'h80020044);
    check("fe_off0_count", fetch_count_32, 32'd11);
    tick();
    #1;
    check_issue("fe_off1", 1'b0, 32'h0);
    check_head("fe_off1", 1'b1, 32'h80020048);
    tick();
    #1;
    check_head("fe_off2", 1'b0, 32'h0);
    check("fe_off2_count", fetch_count_32, 32'd13);
    tick();

    // Reset in the cycle after an issue
    fetch_enable = 1'b1;
    #1;
    check_issue("pre_rst", 1'b1, 32'h4C);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    check("mid_rst_instr", instr_32, 32'h0);
    check("mid_rst_pc", instr_pc_32, 32'h0);
    check("mid_rst_count", fetch_count_32, 32'h0);
    check("mid_rst_addr", mem_addr_32, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check_issue("rel2", 1'b0, 32'h0);
    check_head("rel2", 1'b0, 32'h0);
    tick();
    #1;
    check_issue("restart0", 1'b1, 32'h0);
    check_head("restart0", 1'b0, 32'h0);
    tick();
    #1;
    check_issue("restart1", 1'b1, 32'h4);
    check_head("restart1", 1'b0, 32'h0);
    tick();
    #1;
    check_head("restart2", 1'b1, BASE);
    check("restart2_count", fetch_count_32, 32'h0);

    // Transfer counter wrap
    force dut.fetch_count_q = 32'hFFFFFFFF;
    #1;
    release dut.fetch_count_q;
    #1;
    check("wrap_preload", fetch_count_32, 32'hFFFFFFFF);
    tick();
    #1;
    check("wrap_count", fetch_count_32, 32'h0);
    check_head("wrap_head", 1'b1, BASE + 32'h4);
    tick();
    #1;
    check("wrap_next", fetch_count_32, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
